// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out shifter.
package piso_pkg;

    // Direction in which the register contents move on each shift.
    typedef enum logic {
        SHIFT_TOWARD_MSB = 1'b0,  // MSB leaves first, zero enters at bit 0
        SHIFT_TOWARD_LSB = 1'b1   // LSB leaves first, zero enters at the top
    } shift_dir_t;

    // Bits needed to count from 0 up to and including w.
    function automatic int unsigned cnt_bits(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    // Map the top-level ordering flag onto a shift direction.
    function automatic shift_dir_t dir_from_flag(input bit msb_first);
        return msb_first ? SHIFT_TOWARD_MSB : SHIFT_TOWARD_LSB;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Shift register with synchronous clear and parallel load.
// It shifts on every cycle that is neither a clear nor a load, and
// exposes only the bit that is about to leave the register.
module piso_shift_reg
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter shift_dir_t  DIR   = SHIFT_TOWARD_MSB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    output logic             q
);

    logic [WIDTH-1:0] shreg;

    // Clear beats load, load beats shift; zeros fill behind the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= d_in;
        end else if (DIR == SHIFT_TOWARD_MSB) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end else begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
    end

    // Serial output taken straight from the register end that leaves next.
    always_comb begin
        q = (DIR == SHIFT_TOWARD_MSB) ? shreg[WIDTH-1] : shreg[0];
    end

endmodule

// File: rtl/piso.sv
// Parallel-in/serial-out shifter: captures a WIDTH-bit word on load and
// sends it one bit per clock, flagging busy while unsent bits remain.
module piso
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    output logic             q,
    output logic             busy
);

    localparam int unsigned CW = cnt_bits(WIDTH);

    logic [CW-1:0] cnt;

    piso_shift_reg #(
        .WIDTH (WIDTH),
        .DIR   (dir_from_flag(MSB_FIRST))
    ) u_shift_reg (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .d_in (d_in),
        .q    (q)
    );

    // Remaining-bit counter: restart on load, count down to zero and hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(WIDTH);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Busy whenever loaded bits have not all been sent.
    always_comb begin
        busy = (cnt != '0);
    end

endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: one MSB-first and one LSB-first instance.
// Each step drives inputs, queues the expected {q, busy} after the next
// rising edge, then pops and compares one time unit after that edge.
module tb_piso;

    logic       clk;
    logic       rst_m, load_m;
    logic [3:0] d_m;
    logic       q_m, busy_m;
    logic       rst_l, load_l;
    logic [3:0] d_l;
    logic       q_l, busy_l;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [1:0] exp_m[$];
    logic [1:0] exp_l[$];

    piso #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk  (clk),
        .rst  (rst_m),
        .load (load_m),
        .d_in (d_m),
        .q    (q_m),
        .busy (busy_m)
    );

    piso #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk  (clk),
        .rst  (rst_l),
        .load (load_l),
        .d_in (d_l),
        .q    (q_l),
        .busy (busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MSB-first instance: apply one edge of stimulus and check the result.
    task automatic step_m(input string tag, input logic r, input logic l,
                          input logic [3:0] d, input logic eq, input logic eb);
        logic [1:0] e;
        rst_m  = r;
        load_m = l;
        d_m    = d;
        exp_m.push_back({eq, eb});
        @(posedge clk);
        #1;
        e = exp_m.pop_front();
        checks++;
        assert ({q_m, busy_m} === e) else begin
            errors++;
            $error("FAIL %s: observed q=%b busy=%b expected q=%b busy=%b",
                   tag, q_m, busy_m, e[1], e[0]);
        end
    endtask

    // LSB-first instance: same pattern.
    task automatic step_l(input string tag, input logic r, input logic l,
                          input logic [3:0] d, input logic eq, input logic eb);
        logic [1:0] e;
        rst_l  = r;
        load_l = l;
        d_l    = d;
        exp_l.push_back({eq, eb});
        @(posedge clk);
        #1;
        e = exp_l.pop_front();
        checks++;
        assert ({q_l, busy_l} === e) else begin
            errors++;
            $error("FAIL %s: observed q=%b busy=%b expected q=%b busy=%b",
                   tag, q_l, busy_l, e[1], e[0]);
        end
    endtask

    initial begin
        rst_m = 1'b1; load_m = 1'b0; d_m = 4'b0000;
        rst_l = 1'b1; load_l = 1'b0; d_l = 4'b0000;

        // Reset wins over a simultaneous load.
        step_m("reset_0", 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
        step_m("reset_1", 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
        step_l("reset_l", 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
        step_l("idle_l",  1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Basic MSB-first shift of 1101.
        step_m("basic_ld", 1'b0, 1'b1, 4'b1101, 1'b1, 1'b1);
        step_m("basic_s1", 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        step_m("basic_s2", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        step_m("basic_s3", 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        step_m("basic_s4", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        step_m("basic_s5", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Reload mid-word abandons 1101 and restarts with 0010.
        step_m("reld_ld1", 1'b0, 1'b1, 4'b1101, 1'b1, 1'b1);
        step_m("reld_s1",  1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        step_m("reld_s2",  1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        step_m("reld_ld2", 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1);
        step_m("reld_t1",  1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        step_m("reld_t2",  1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        step_m("reld_t3",  1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        step_m("reld_t4",  1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Load held for three edges keeps presenting the first bit.
        step_m("held_1", 1'b0, 1'b1, 4'b1000, 1'b1, 1'b1);
        step_m("held_2", 1'b0, 1'b1, 4'b1000, 1'b1, 1'b1);
        step_m("held_3", 1'b0, 1'b1, 4'b1000, 1'b1, 1'b1);
        step_m("held_r1", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        step_m("held_r2", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        step_m("held_r3", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        step_m("held_r4", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Reset in the middle of a word clears everything.
        step_m("rmid_ld",  1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
        step_m("rmid_s1",  1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        step_m("rmid_rst", 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        step_m("rmid_aft", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);

        // LSB-first instance sends d_in[0] first.
        step_l("lsb_ld", 1'b0, 1'b1, 4'b1101, 1'b1, 1'b1);
        step_l("lsb_s1", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        step_l("lsb_s2", 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        step_l("lsb_s3", 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        step_l("lsb_s4", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        step_l("lsb_ld2", 1'b0, 1'b1, 4'b0110, 1'b0, 1'b1);
        step_l("lsb_t1",  1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        step_l("lsb_t2",  1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        step_l("lsb_t3",  1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        step_l("lsb_t4",  1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no completion expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
